// File: rtl/ks_pipelined_subtractor.sv
// ----------------------------------------------------------------------------
// ks_pipelined_subtractor
//
// Pipelined Kogge-Stone subtractor: diff = (a - b - bin) mod 2^WIDTH, with
// borrow-out. Computed as a + ~b + cin (cin = ~bin) through a generate /
// propagate prefix network, with one register stage per prefix level.
//
// Stages (LEVELS + 2 total):
//   stage 0         : bitwise G/P of a and ~b, cin, original P (for the sum)
//   stage 1..LEVELS : prefix level j combines bit i with bit i - 2^(j-1)
//   output stage    : carries, diff, bout (and ovf) registered onto the ports
//
// Flow control is a single global advance, adv = !out_valid || out_ready.
// Every stage shifts on adv and holds otherwise; bubbles are kept, so order
// is preserved and latency is fixed at LEVELS + 1 edges after acceptance.
//
// Optional feature: define KS_SUB_OVF_EN to add the signed-overflow port
// `ovf`, fed by the operand MSBs carried alongside the data.
//
// Parameters:
//   WIDTH   operand width, power of two from 4 to 64
//   LEVELS  number of prefix levels, $clog2(WIDTH); derived
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands present
//   in_ready   pipeline accepts operands this cycle (combinational from
//              out_valid / out_ready only)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result present
//   out_ready  consumer accepts the result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       1 when a < b + bin (unsigned)
//   ovf        signed overflow (KS_SUB_OVF_EN only)
// ----------------------------------------------------------------------------
module ks_pipelined_subtractor #(
    parameter int WIDTH  = 16,
    parameter int LEVELS = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef KS_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // ------------------------------------------------------------------------
    // Pipeline registers, index = stage number (0 .. LEVELS)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] g_q  [0:LEVELS];
    logic [WIDTH-1:0] p_q  [0:LEVELS];
    logic [WIDTH-1:0] po_q [0:LEVELS];
    logic             cin_q[0:LEVELS];
    logic             v_q  [0:LEVELS];
`ifdef KS_SUB_OVF_EN
    logic             am_q [0:LEVELS];
    logic             bm_q [0:LEVELS];
`endif

    // Next values for prefix stages 1 .. LEVELS
    logic [WIDTH-1:0] g_nx [1:LEVELS];
    logic [WIDTH-1:0] p_nx [1:LEVELS];

    logic             adv;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff_nx;
    logic             bout_nx;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_inv    = ~b;

    // ------------------------------------------------------------------------
    // Prefix levels. Shifting the lower neighbour in by K brings G[i-K] and
    // P[i-K] to bit i. For i < K the shifted-in zeros leave G unchanged, and
    // the low mask forces P[i] through unchanged as well.
    // ------------------------------------------------------------------------
    for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
        localparam int               K   = 1 << (j - 1);
        localparam logic [WIDTH-1:0] LOW = WIDTH'((65'd1 << K) - 65'd1);

        assign g_nx[j] = g_q[j-1] | (p_q[j-1] & (g_q[j-1] << K));
        assign p_nx[j] = p_q[j-1] & ((p_q[j-1] << K) | LOW);
    end

    // ------------------------------------------------------------------------
    // Output stage logic. After the last level, G[i]/P[i] are the group
    // generate/propagate over bits i..0, so each carry needs only cin.
    // ------------------------------------------------------------------------
    always_comb begin
        carry[0] = cin_q[LEVELS];
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = g_q[LEVELS][i] | (p_q[LEVELS][i] & cin_q[LEVELS]);
        end
        diff_nx = po_q[LEVELS] ^ carry[WIDTH-1:0];
        bout_nx = ~carry[WIDTH];
    end

`ifdef KS_SUB_OVF_EN
    logic ovf_nx;

    assign ovf_nx = (am_q[LEVELS] ^ bm_q[LEVELS]) & (am_q[LEVELS] ^ diff_nx[WIDTH-1]);
`endif

    // ------------------------------------------------------------------------
    // Register stages. Data registers load on every advance whether or not
    // the stage holds a valid item; only the valid bits give them meaning.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= LEVELS; j++) begin
                g_q[j]   <= '0;
                p_q[j]   <= '0;
                po_q[j]  <= '0;
                cin_q[j] <= 1'b0;
                v_q[j]   <= 1'b0;
`ifdef KS_SUB_OVF_EN
                am_q[j]  <= 1'b0;
                bm_q[j]  <= 1'b0;
`endif
            end
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
`ifdef KS_SUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (adv) begin
            // adv doubles as in_ready, so in_valid alone marks acceptance.
            v_q[0]   <= in_valid;
            g_q[0]   <= a & b_inv;
            p_q[0]   <= a ^ b_inv;
            po_q[0]  <= a ^ b_inv;
            cin_q[0] <= ~bin;
`ifdef KS_SUB_OVF_EN
            am_q[0]  <= a[WIDTH-1];
            bm_q[0]  <= b[WIDTH-1];
`endif
            for (int j = 1; j <= LEVELS; j++) begin
                g_q[j]   <= g_nx[j];
                p_q[j]   <= p_nx[j];
                po_q[j]  <= po_q[j-1];
                cin_q[j] <= cin_q[j-1];
                v_q[j]   <= v_q[j-1];
`ifdef KS_SUB_OVF_EN
                am_q[j]  <= am_q[j-1];
                bm_q[j]  <= bm_q[j-1];
`endif
            end
            out_valid <= v_q[LEVELS];
            diff      <= diff_nx;
            bout      <= bout_nx;
`ifdef KS_SUB_OVF_EN
            ovf       <= ovf_nx;
`endif
        end
    end

endmodule

// File: tb/tb_ks_pipelined_subtractor.sv
// ----------------------------------------------------------------------------
// Self-checking bench for ks_pipelined_subtractor (WIDTH = 16).
// Inputs change 1 ns after the rising edge; the DUT is sampled on the falling
// edge. A monitor pairs every accepted operand set with its expected result
// in a queue and checks results in order as they are consumed.
// ----------------------------------------------------------------------------
module tb_ks_pipelined_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef KS_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    ks_pipelined_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef KS_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    exp_t expq[$];
    exp_t exp_drv;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_out   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %0h want %0h", name, got, want);
    endtask

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic bi);
        logic [W:0] r;
        exp_t       e;
        r    = {1'b0, aa} - {1'b0, bb} - {{W{1'b0}}, bi};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (aa[W-1] ^ bb[W-1]) & (aa[W-1] ^ r[W-1]);
        return e;
    endfunction

    // Result monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                exp_t e;
                n_out++;
                if (expq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("diff_bout", {bout, diff}, {e.bo, e.d});
`ifdef KS_SUB_OVF_EN
                    chk("ovf", ovf, e.ov);
`endif
                end
            end
            if (in_valid && in_ready) expq.push_back(exp_drv);
        end
    end

    task automatic tick(output logic acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                        input exp_t e);
        logic acc;
        int   guard;
        guard    = 0;
        a        = aa;
        b        = bb;
        bin      = bi;
        exp_drv  = e;
        in_valid = 1'b1;
        do begin
            tick(acc);
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic acc;
        int   guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (expq.size() > 0 && guard < 100) begin
            tick(acc);
            guard++;
        end
        chk(name, expq.size(), 0);
    endtask

    vec_t vecs[12];

    initial begin
        logic acc;
        int   lat;
        int   idx;
        int   stall_left;
        int   stall_done;
        int   out0;
        int   cnt;
        int   sent;
        logic have;
        exp_t e;

        vecs[0]  = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1]  = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4]  = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[5]  = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6]  = '{16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[8]  = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[10] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{16'h00FF, 16'h0F00, 1'b0, 16'hF1FF, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        exp_drv   = '0;

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
`ifdef KS_SUB_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);

        // Basic vector and latency: accepted at edge N, visible after N+5
        a        = 16'h0005;
        b        = 16'h0003;
        bin      = 1'b0;
        exp_drv  = '{16'h0002, 1'b0, 1'b0};
        in_valid = 1'b1;
        tick(acc);
        chk("first_edge_accept", acc, 1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick(acc);
            lat++;
        end
        chk("latency", lat, 5);
        drain("drain_basic");

        // Table of directed vectors, streamed back to back
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].bin, '{vecs[i].d, vecs[i].bo, vecs[i].ov});
        end
        drain("drain_table");

        // Back-to-back with a 3-cycle stall after the first result appears
        idx        = 1;
        stall_left = 0;
        stall_done = 0;
        out0       = n_out;
        out_ready  = 1'b1;
        for (int cyc = 0; cyc < 200 && (idx <= 8 || expq.size() > 0); cyc++) begin
            if (idx <= 8) begin
                a        = W'(32'h1111 * idx);
                b        = W'(idx);
                bin      = 1'b0;
                exp_drv  = '{W'(32'h1110 * idx), 1'b0, 1'b0};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (!stall_done && stall_left == 0 && out_valid) stall_left = 3;
            out_ready = !(stall_left > 0);
            @(negedge clk);
            if (stall_left > 0) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_seen", stall_done, 1);
        chk("stall_result_count", n_out - out0, 8);
        drain("drain_stall");

        // Reset with four items in flight
        for (int i = 0; i < 4; i++) begin
            send(W'(16'h4321 + 16'h0F0F * i), 16'h0123, 1'b1,
                 model(W'(16'h4321 + 16'h0F0F * i), 16'h0123, 1'b1));
        end
        tick(acc);
        chk("inflight_before_reset", expq.size(), 4);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        expq.delete();
        tick(acc);
        tick(acc);
        rst_n = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick(acc);
            if (out_valid) cnt++;
        end
        chk("post_reset_emerge", cnt, 0);

        // Random traffic against the arithmetic reference model
        sent = 0;
        have = 1'b0;
        for (int cyc = 0; cyc < 80000 && sent < 10000; cyc++) begin
            if (!have) begin
                a       = W'($urandom);
                b       = W'($urandom);
                bin     = 1'($urandom_range(0, 1));
                exp_drv = model(a, b, bin);
                have    = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) begin
                sent++;
                have = 1'b0;
            end
        end
        chk("random_sent", sent, 10000);
        drain("drain_random");

        e = '0;
        chk("final_queue_empty", expq.size(), e.d);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ks_pipelined_subtractor.md
# ks_pipelined_subtractor

- Pipelined Kogge-Stone subtractor: computes `diff = a - b - bin` over `WIDTH` bits and produces a borrow-out.
- Same generate/propagate prefix network as the team's exact Kogge-Stone adder, run in the subtract direction and split into one register stage per prefix level.
- Sits between operand producers and result consumers behind a valid/ready handshake. It is the registered counterpart used wherever the design takes differences instead of sums.

## Interface
Parameters:
- `WIDTH`, default 16. Operand width; must be a power of two, 4 to 64.
- `LEVELS`, default `$clog2(WIDTH)`. Number of prefix levels; derived, not overridden.

Ports (one clock, `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  pipeline can accept operands this cycle.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow-out: 1 when `a < b + bin` (unsigned).
- `ovf`  out  1  signed overflow; present only with `KS_SUB_OVF_EN`.

## Operation
- Subtraction is done as `a + ~b + cin` with `cin = ~bin`. Then `bout = ~carry_out`.
- Stage 0 registers:
  - `P[i] = a[i] ^ ~b[i]` and `G[i] = a[i] & ~b[i]` for every bit.
  - `cin`.
  - The original `P` vector, kept for the sum.
  - With the macro: `a[WIDTH-1]` and `b[WIDTH-1]`.
- Stages 1..`LEVELS`: stage `j` applies prefix distance `k = 2^(j-1)`:
  - For `i >= k`: `G' = G[i] | (P[i] & G[i-k])` and `P' = P[i] & P[i-k]`.
  - For `i < k`: bits pass through unchanged.
- Output stage:
  - `c[0] = cin` and `c[i+1] = G[i] | (P[i] & cin)`.
  - `diff[i] = Porig[i] ^ c[i]`.
  - `bout = ~c[WIDTH]`.
- Every stage carries a valid bit. Stages holding invalid data still clock, but their contents are don't-care.
- Flow control uses one global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - Operands are accepted when `in_valid && in_ready`.
  - When `adv` is 0, every stage holds, valid bits included.
  - When `adv` is 1, every stage shifts by one. A stage-0 valid bit of 0 enters when no operands are accepted.
  - Bubbles are not squeezed out.
- Results leave in exactly acceptance order. None are dropped or duplicated.

## Timing
- Pipeline depth is `LEVELS + 2` register stages: 6 for `WIDTH = 16`.
- Latency with no stall: operands accepted at edge N give `out_valid = 1` with the result after edge N+5 (for 16 bits). In general the result appears after edge N + `LEVELS` + 1.
- Each stall cycle (`out_valid && !out_ready`) adds one cycle to every in-flight item.
- Throughput is one result per cycle while `out_ready` stays 1.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid` to any output.
- Outputs come straight from flops: `diff`, `bout`, `ovf`, `out_valid`.
- Reset values, applied asynchronously by `rst_n = 0`: all valid bits 0, `out_valid = 0`, `diff = 0`, `bout = 0`, `ovf = 0`. Internal data registers are also 0.
- Reset in the middle of operation discards every in-flight item; nothing emerges after release.
- After `rst_n` rises, the first edge already accepts operands, with `in_ready = 1`.
- Boundary cases:
  - `a = b`, `bin = 0` → `diff = 0`, `bout = 0`.
  - `a = b`, `bin = 1` → all-ones, `bout = 1`.
  - `b = 0`, `bin = 0` → `diff = a`, `bout = 0`.

## Configuration
- `KS_SUB_OVF_EN` defined:
  - Adds port `ovf`, computed in the output stage as `(a_msb ^ b_msb) & (a_msb ^ diff_msb)`.
  - The MSBs are carried through the pipeline alongside the data.
- Not defined:
  - Port `ovf` and its pipeline registers do not exist.
  - All other behaviour and latency are identical.

## Test plan
- Basic: `a=0x0005`, `b=0x0003`, `bin=0`, `out_ready=1` → 5 cycles later `diff=0x0002`, `bout=0`.
- Wrap: `a=0x0003`, `b=0x0005`, `bin=0` → `diff=0xFFFE`, `bout=1`. Also `a=0`, `b=0`, `bin=1` → `diff=0xFFFF`, `bout=1`.
- Carry chain: `a=0x8000`, `b=0x0001`, `bin=0` → `diff=0x7FFF`, `bout=0`. With `KS_SUB_OVF_EN`, `ovf=1`.
- Back-to-back with stall:
  - Stimulus: 8 consecutive operand pairs `a=i*0x1111`, `b=i`, `bin=0`; `out_ready=0` for 3 cycles after the first result appears.
  - Required: `in_ready=0` during the stall; all 8 results are correct, in order, with no loss or duplication.
- Reset mid-flight: assert `rst_n=0` with 4 items in flight → `out_valid=0`, `diff=0` immediately; no item emerges after release.
- Random: 10k random `a`/`b`/`bin` with random `in_valid`/`out_ready` → every result matches the reference model `{bout,diff} = {1'b0,a} - b - bin` (borrow taken from bit `WIDTH`).
